// File: rtl/spwm_pkg.sv
// Shared constants, FSM encodings and index helper for the sinusoidal-PWM sequencer.
package spwm_pkg;

  localparam int PERIOD_TOP_DEF = 2499;
  localparam int LUT_DEPTH_DEF  = 111;
  localparam int DUTY_W_DEF     = 12;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRIME = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;

  function automatic int next_idx(input int idx, input int depth);
    return (idx >= depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spwm_pwm_carrier.sv
// Carrier counter with a registered duty comparator; holds at zero while cleared.
module pwm_carrier #(
  parameter int PERIOD_TOP = 2499,
  parameter int DUTY_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  input  logic [DUTY_W-1:0] duty_active,
  output logic [DUTY_W-1:0] cnt,
  output logic              at_top,
  output logic              pwm_out
);

  assign at_top = (cnt == DUTY_W'(PERIOD_TOP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (run)
        cnt <= at_top ? '0 : cnt + DUTY_W'(1);
      // Comparing against the current count keeps the output one clock behind cnt.
      pwm_out <= run && (cnt < duty_active);
    end
  end

endmodule

// File: rtl/spwm_sequencer.sv
// Sequences the sine-duty ROM lookup, double-buffers duty and runs the PWM carrier.
module spwm_sequencer
  import spwm_pkg::*;
#(
  parameter int PERIOD_TOP = PERIOD_TOP_DEF,
  parameter int LUT_DEPTH  = LUT_DEPTH_DEF,
  parameter int IDX_W      = 7,
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int DIV_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  periods_per_step,
  output logic              lut_rd,
  output logic [IDX_W-1:0]  lut_addr,
  input  logic [DUTY_W-1:0] lut_data,
  output logic              pwm_out,
  output logic              period_start,
  output logic              wave_done,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [DIV_W-1:0]    step_cnt;
  logic [DIV_W-1:0]    pps_l;
  logic [DUTY_W-1:0]   duty_shadow;
  logic [DUTY_W-1:0]   duty_active;
  logic [DUTY_W-1:0]   cnt;
  logic                at_top;
  logic                run;
  logic                clear;
  logic                step_last;
  logic                rd_q;

  assign idx_nxt   = IDX_W'(next_idx(int'(idx), LUT_DEPTH));
  assign step_last = (step_cnt == pps_l - DIV_W'(1));
  assign run       = (state == ST_RUN) || (state == ST_DRAIN);
  assign clear     = (state == ST_IDLE) || (state == ST_LOAD);

  // ROM handshake: lut_rd is a one-cycle request carrying lut_addr; there is no
  // back-pressure, and lut_data is taken exactly one clock later (tracked by rd_q).
  assign lut_rd       = (state == ST_PRIME) ||
                        ((state == ST_RUN) && (cnt == '0) && step_last);
  assign lut_addr     = ((state == ST_RUN) && lut_rd) ? idx_nxt : '0;
  assign period_start = (state == ST_RUN) && (cnt == '0);
  assign busy         = (state != ST_IDLE);
  assign state_dbg    = state;

  pwm_carrier #(
    .PERIOD_TOP (PERIOD_TOP),
    .DUTY_W     (DUTY_W)
  ) u_carrier (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .clear       (clear),
    .duty_active (duty_active),
    .cnt         (cnt),
    .at_top      (at_top),
    .pwm_out     (pwm_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      step_cnt    <= '0;
      pps_l       <= '0;
      duty_shadow <= '0;
      duty_active <= '0;
      wave_done   <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      wave_done <= 1'b0;
      rd_q      <= lut_rd;
      case (state)
        ST_IDLE: begin
          idx      <= '0;
          step_cnt <= '0;
          if (enable) begin
            pps_l <= (periods_per_step == '0) ? DIV_W'(1) : periods_per_step;
            state <= ST_PRIME;
          end
        end
        ST_PRIME: state <= ST_LOAD;
        ST_LOAD: begin
          duty_shadow <= lut_data;
          duty_active <= lut_data;
          step_cnt    <= '0;
          state       <= ST_RUN;
        end
        ST_RUN: begin
          if (rd_q)
            duty_shadow <= lut_data;
          // The compare value only moves on the wrap, so a period is never split.
          if (at_top) begin
            if (step_last) begin
              step_cnt    <= '0;
              idx         <= idx_nxt;
              duty_active <= duty_shadow;
              wave_done   <= (idx == IDX_W'(LUT_DEPTH - 1));
            end else begin
              step_cnt <= step_cnt + DIV_W'(1);
            end
          end
          if (!enable)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (at_top)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spwm_sequencer.sv
// Directed bench for spwm_sequencer with a small carrier and a 4-entry duty ROM.
module tb_spwm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  periods_per_step;
  logic        lut_rd;
  logic [6:0]  lut_addr;
  logic [11:0] lut_data;
  logic        pwm_out;
  logic        period_start;
  logic        wave_done;
  logic        busy;
  logic [2:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int highs;
  int rds;

  // clock / reset
  always #5 clk = ~clk;

  spwm_sequencer #(
    .PERIOD_TOP (9),
    .LUT_DEPTH  (4),
    .IDX_W      (7),
    .DUTY_W     (12),
    .DIV_W      (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .periods_per_step (periods_per_step),
    .lut_rd           (lut_rd),
    .lut_addr         (lut_addr),
    .lut_data         (lut_data),
    .pwm_out          (pwm_out),
    .period_start     (period_start),
    .wave_done        (wave_done),
    .busy             (busy),
    .state_dbg        (state_dbg)
  );

  // duty ROM model, one clock of read latency
  function automatic logic [11:0] rom_val(input logic [6:0] a);
    case (a)
      7'd0:    return 12'd3;
      7'd1:    return 12'd7;
      7'd2:    return 12'd0;
      7'd3:    return 12'd12;
      default: return 12'd0;
    endcase
  endfunction

  initial lut_data = '0;
  always @(posedge clk)
    if (lut_rd) lut_data <= rom_val(lut_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One carrier period from cnt==0: counts read strobes and lagged pwm highs.
  task automatic meas_period(input int drop_at, input int raise_at,
                             output int h, output int r);
    h = 0;
    r = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == drop_at)  enable = 1'b0;
      if (i == raise_at) enable = 1'b1;
      r += int'(lut_rd);
      tick();
      h += int'(pwm_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    periods_per_step = 8'd1;
    tick();
    tick();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", lut_rd, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // pps=1 run through a full wave
    enable = 1'b1;
    periods_per_step = 8'd1;
    chk("start_rd_before", lut_rd, 0);
    tick();
    chk("prime_state", state_dbg, 1);
    chk("prime_rd", lut_rd, 1);
    chk("prime_addr", lut_addr, 0);
    chk("prime_busy", busy, 1);
    tick();
    chk("load_state", state_dbg, 2);
    chk("load_rd", lut_rd, 0);
    tick();
    chk("run_state", state_dbg, 3);
    chk("run_pstart", period_start, 1);
    chk("run_pwm_c0", pwm_out, 0);
    chk("run_rd_c0", lut_rd, 1);
    chk("run_addr_c0", lut_addr, 1);
    meas_period(-1, -1, highs, rds);
    chk("p1_highs", highs, 3);
    chk("p1_rds", rds, 1);
    chk("p2_wave_done", wave_done, 0);
    meas_period(-1, -1, highs, rds);
    chk("p2_highs", highs, 7);
    meas_period(-1, -1, highs, rds);
    chk("p3_highs", highs, 0);
    chk("p4_addr", lut_addr, 0);
    chk("p4_pstart", period_start, 1);
    meas_period(-1, -1, highs, rds);
    chk("p4_highs", highs, 10);
    chk("p5_wave_done", wave_done, 1);
    chk("p5_addr", lut_addr, 1);
    meas_period(-1, -1, highs, rds);
    chk("p5_highs", highs, 3);
    chk("p6_wave_done", wave_done, 0);

    // stop at cnt=4 of a duty-7 period
    meas_period(4, -1, highs, rds);
    chk("drain_highs", highs, 7);
    chk("drain_rds", rds, 1);
    chk("drain_end_busy", busy, 0);
    chk("drain_end_state", state_dbg, 0);
    chk("drain_end_rd", lut_rd, 0);
    tick();
    chk("drain_after_pwm", pwm_out, 0);
    chk("drain_after_busy", busy, 0);

    // pps=3: each duty held for three periods
    enable = 1'b1;
    periods_per_step = 8'd3;
    tick();
    tick();
    tick();
    periods_per_step = 8'd1;
    chk("pps3_pstart", period_start, 1);
    chk("pps3_rd_c0", lut_rd, 0);
    meas_period(-1, -1, highs, rds);
    chk("pps3_a_highs", highs, 3);
    chk("pps3_a_rds", rds, 0);
    meas_period(-1, -1, highs, rds);
    chk("pps3_b_highs", highs, 3);
    chk("pps3_b_rds", rds, 0);
    meas_period(-1, -1, highs, rds);
    chk("pps3_c_highs", highs, 3);
    chk("pps3_c_rds", rds, 1);
    meas_period(-1, -1, highs, rds);
    chk("pps3_d_highs", highs, 7);
    chk("pps3_d_rds", rds, 0);

    // asynchronous reset while pwm_out is high
    tick();
    tick();
    chk("pre_rst_pwm", pwm_out, 1);
    reset = 1'b1;
    enable = 1'b0;
    periods_per_step = 8'd0;
    #1;
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_pstart", period_start, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_state", state_dbg, 0);

    // pps=0 behaves as pps=1, restarting from index 0
    enable = 1'b1;
    tick();
    chk("pps0_prime_rd", lut_rd, 1);
    chk("pps0_prime_addr", lut_addr, 0);
    tick();
    tick();
    chk("pps0_rd_c0", lut_rd, 1);
    chk("pps0_addr_c0", lut_addr, 1);
    meas_period(-1, -1, highs, rds);
    chk("pps0_a_highs", highs, 3);
    chk("pps0_a_rds", rds, 1);
    meas_period(-1, -1, highs, rds);
    chk("pps0_b_highs", highs, 7);

    // enable re-raised during DRAIN is ignored until IDLE
    meas_period(2, 5, highs, rds);
    chk("redrain_highs", highs, 0);
    chk("redrain_rds", rds, 1);
    chk("redrain_end_state", state_dbg, 0);
    tick();
    chk("restart_state", state_dbg, 1);
    chk("restart_rd", lut_rd, 1);
    chk("restart_addr", lut_addr, 0);
    tick();
    tick();
    meas_period(-1, -1, highs, rds);
    chk("restart_highs", highs, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
